bsram_sp_ctrl: RTL and testbench
================================

Name: bsram_sp_ctrl

Overview:
- Parametrised single-port block-RAM wrapper. Successor to the fixed 2048x16 single-port macro.
- Adds:
  - configurable data and address width
  - per-byte write enables
  - selectable write-collision mode
  - optional output pipeline register
  - hardware clear sequencer that sweeps the whole array after reset
- Sits between the CPU bus/LED logic and on-chip BSRAM. Synthesises to inferred BSRAM.

Parameters:
- DATA_W, 16: data width in bits; must be a multiple of 8.
- ADDR_W, 11: address width; depth = 2^ADDR_W words.
- READ_MODE, 0: 0 = bypass, read latency 1; 1 = pipeline, read latency 2 via oce-gated output register.
- WRITE_MODE, 0: 0 = normal, dout holds on write; 1 = write-through, dout = newly written word; 2 = read-before-write, dout = old word.
- CLEAR_ON_RESET, 1: 1 = sweep array with CLEAR_VALUE after reset; 0 = no clear, contents undefined at power-up.
- CLEAR_VALUE, 0: word written to every address during the clear sweep.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: synchronous reset, active-low; sampled on rising clk.
- ce, input, 1: access enable for this cycle.
- oce, input, 1: output-register clock enable; used only when READ_MODE=1.
- wre, input, 1: 1 = write, 0 = read; qualified by ce.
- be, input, DATA_W/8: byte enables; be[i] covers din[8i+7:8i]; used on writes only.
- ad, input, ADDR_W: word address.
- din, input, DATA_W: write data.
- dout, output, DATA_W: read data.
- rd_valid, output, 1: dout carries a fresh result this cycle.
- busy, output, 1: clear sweep in progress; accesses ignored.

Behaviour:

Reset (reset=0 at an edge):
- dout, stage-1 register, stage-2 register, rd_valid all <= 0.
- clr_addr <= 0.
- FSM <= CLEAR if CLEAR_ON_RESET=1, else IDLE.
- Array contents are not otherwise touched by reset.
- busy = 1 during reset when CLEAR_ON_RESET=1, so busy is high from the first cycle after release.

FSM:
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle, mem[clr_addr] <= CLEAR_VALUE (all bytes) and clr_addr++.
  - When clr_addr = 2^ADDR_W-1, write it and go to IDLE next edge.
  - busy=1 for exactly 2^ADDR_W cycles after reset release.
- IDLE: busy=0. Normal access.
- Reset asserted mid-sweep: sweep restarts from address 0 after release.

Access (IDLE, ce=1 at an edge):
- wre=0: stage1 <= mem[ad]; s1_valid <= 1.
- wre=1:
  - For every i with be[i]=1, mem[ad] byte i <= din byte i; bytes with be[i]=0 are unchanged.
  - be all-zero is a legal no-op write.
- Stage-1 result on a write:
  - WRITE_MODE 0: stage1 holds; s1_valid <= 0.
  - WRITE_MODE 1: stage1 <= merged word (din where be=1, old data elsewhere); s1_valid <= 1.
  - WRITE_MODE 2: stage1 <= old mem[ad] before the write; s1_valid <= 1.

No access (ce=0, or busy=1):
- stage1 holds; s1_valid <= 0; no array write.
- ce during busy is dropped silently.

Output:
- READ_MODE 0: dout = stage1; rd_valid = s1_valid. Latency 1 edge from access.
- READ_MODE 1:
  - On an edge with oce=1: stage2 <= stage1 and v2 <= s1_valid.
  - On an edge with oce=0: stage2 holds and v2 <= 0.
  - dout = stage2; rd_valid = v2. Latency 2 edges when oce is held high.

Back-to-back: a new access every cycle is supported at full throughput, including a read of the address written on the previous cycle (returns the new data).

Test Plan:
1. Defaults, CLEAR_VALUE=0: release reset -> busy=1 for exactly 2048 cycles, then 0. Then read ad=0x7FF -> dout=0x0000 and rd_valid=1 one cycle later.
2. Write ad=0x000 din=0x78A1 be=2'b11, then read ad=0x000 -> dout=0x78A1 with rd_valid=1 at latency 1. Back-to-back write/read of ad=0x001 with 0x9066 -> 0x9066.
3. Byte enable: ad=0x001 holds 0x9066; write din=0xFFFF be=2'b01, then read -> 0x90FF. Write with be=2'b00, then read -> 0x90FF unchanged.
4. Write collision at ad=0x001 holding 0x90FF, writing 0x1234 be=2'b11:
   - WRITE_MODE 0: dout holds its prior value, rd_valid=0.
   - WRITE_MODE 1: dout=0x1234, rd_valid=1.
   - WRITE_MODE 2: dout=0x90FF, rd_valid=1.
   - Subsequent read in every mode -> 0x1234.
5. READ_MODE 1:
   - With oce=1, read of 0x78A1 appears two edges after the access.
   - With oce=0 held 3 cycles after the access, dout keeps its previous value and rd_valid=0.
   - Raising oce then presents 0x78A1 with rd_valid=1.
6. Reset mid-sweep and during access:
   - Assert reset at busy cycle 100 -> dout=0, rd_valid=0; on release busy is high again for 2048 cycles.
   - ce=1 wre=1 ad=0x005 din=0xBEEF during busy is ignored; read after sweep -> 0x0000.

Source files
------------

// File: rtl/bsram_sp_ctrl.sv
// rtl/bsram_sp_ctrl.sv - parametrised single-port BSRAM wrapper with byte enables and clear sweep
module bsram_sp_ctrl #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 11,
  parameter int unsigned       READ_MODE      = 0,
  parameter int unsigned       WRITE_MODE     = 0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     ad,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [DATA_W-1:0]   s1_q, s2_q;
  logic                s1v_q, s2v_q;

  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  logic [DATA_W-1:0]   old_word, merged_word;
  logic                access, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;

  assign busy     = (state_q == ST_CLEAR);
  assign access   = ce && !busy;
  assign old_word = mem[ad];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[8*i +: 8] = din[8*i +: 8];
    end
  end

  // The sweep owns the write port while busy; nothing touches the array during reset.
  assign mem_we    = reset && (busy || (ce && wre));
  assign mem_addr  = busy ? clr_addr_q : ad;
  assign mem_wdata = busy ? CLEAR_VALUE : din;
  assign mem_be    = busy ? {NB{1'b1}} : be;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
      s1_q       <= '0;
      s1v_q      <= 1'b0;
      s2_q       <= '0;
      s2v_q      <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_W{1'b1}}) state_q <= ST_IDLE;
      end

      if (access && !wre) begin
        s1_q  <= old_word;
        s1v_q <= 1'b1;
      end else if (access && WRITE_MODE == 1) begin
        s1_q  <= merged_word;
        s1v_q <= 1'b1;
      end else if (access && WRITE_MODE == 2) begin
        s1_q  <= old_word;
        s1v_q <= 1'b1;
      end else begin
        s1v_q <= 1'b0;
      end

      // Output register only advances on oce; a stalled cycle never reports valid.
      if (oce) begin
        s2_q  <= s1_q;
        s2v_q <= s1v_q;
      end else begin
        s2v_q <= 1'b0;
      end
    end
  end

  assign dout     = (READ_MODE == 1) ? s2_q  : s1_q;
  assign rd_valid = (READ_MODE == 1) ? s2v_q : s1v_q;

endmodule

// File: tb/tb_bsram_sp_ctrl.sv
// tb/tb_bsram_sp_ctrl.sv - randomized and directed bench for bsram_sp_ctrl against a reference model
module tb_bsram_sp_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, oce, wre;
  logic [1:0]  be;
  logic [10:0] ad;
  logic [15:0] din;

  // Instances 0..2: bypass read, write modes 0/1/2. Instance 3: pipelined read, write mode 0.
  logic [15:0] dout_a [4];
  logic        rv_a   [4];
  logic        busy_a [4];

  bsram_sp_ctrl #(.READ_MODE(0), .WRITE_MODE(0)) u_wm0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .dout(dout_a[0]), .rd_valid(rv_a[0]), .busy(busy_a[0]));
  bsram_sp_ctrl #(.READ_MODE(0), .WRITE_MODE(1)) u_wm1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .dout(dout_a[1]), .rd_valid(rv_a[1]), .busy(busy_a[1]));
  bsram_sp_ctrl #(.READ_MODE(0), .WRITE_MODE(2)) u_wm2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .dout(dout_a[2]), .rd_valid(rv_a[2]), .busy(busy_a[2]));
  bsram_sp_ctrl #(.READ_MODE(1), .WRITE_MODE(0)) u_rm1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .dout(dout_a[3]), .rd_valid(rv_a[3]), .busy(busy_a[3]));

  logic [15:0] ref_mem [2048];
  logic [15:0] ew [3];
  bit          ev [3];
  logic [15:0] pw;
  bit          pv;
  int          busy_left;
  int          total = 0;
  int          bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] old, mask, merged;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin ew[k] = '0; ev[k] = 0; end
      pw = '0; pv = 0;
      busy_left = 2048;
      for (int a = 0; a < 2048; a++) ref_mem[a] = '0;
    end else begin
      if (oce) begin pw = ew[0]; pv = ev[0]; end
      else pv = 0;
      if (busy_left > 0) begin
        busy_left--;
        for (int k = 0; k < 3; k++) ev[k] = 0;
      end else if (ce) begin
        old    = ref_mem[ad];
        mask   = {{8{be[1]}}, {8{be[0]}}};
        merged = (old & ~mask) | (din & mask);
        if (!wre) begin
          for (int k = 0; k < 3; k++) begin ew[k] = old; ev[k] = 1; end
        end else begin
          ev[0] = 0;
          ew[1] = merged; ev[1] = 1;
          ew[2] = old;    ev[2] = 1;
          ref_mem[ad] = merged;
        end
      end else begin
        for (int k = 0; k < 3; k++) ev[k] = 0;
      end
    end
  endtask

  task automatic cycle(input bit c, input bit w, input logic [1:0] b, input logic [10:0] a,
                       input logic [15:0] d, input bit o, input bit r);
    reset = r; ce = c; wre = w; be = b; ad = a; din = d; oce = o;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("busy_%0d", k), {31'b0, busy_a[k]}, {31'b0, busy_left > 0});
      check_eq($sformatf("dout_%0d", k), {16'b0, dout_a[k]}, {16'b0, (k < 3) ? ew[k] : pw});
      check_eq($sformatf("rv_%0d", k), {31'b0, rv_a[k]}, {31'b0, (k < 3) ? ev[k] : pv});
    end
  endtask

  task automatic idle(input bit o);
    cycle(0, 0, 2'b00, 11'h0, 16'h0, o, 1);
  endtask
  task automatic rd(input logic [10:0] a, input bit o);
    cycle(1, 0, 2'b00, a, 16'h0, o, 1);
  endtask
  task automatic wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] b);
    cycle(1, 1, b, a, d, 1, 1);
  endtask

  task automatic sweep_len(input bit poke, output int n);
    n = busy_a[0] ? 1 : 0;
    for (int i = 0; i < 5000 && busy_a[0]; i++) begin
      if (poke) cycle(1, 1, 2'b11, 11'h005, 16'hBEEF, 1, 1);
      else      idle(1);
      if (busy_a[0]) n++;
    end
  endtask

  initial begin
    int n;
    cycle(0, 0, 2'b00, 11'h0, 16'h0, 1, 0);
    cycle(0, 0, 2'b00, 11'h0, 16'h0, 1, 0);
    check_eq("rst_dout", {16'b0, dout_a[0]}, 32'h0);
    check_eq("rst_busy", {31'b0, busy_a[0]}, 32'h1);

    sweep_len(0, n);
    check_eq("t1_busy_len", n, 2048);
    rd(11'h7FF, 1);
    check_eq("t1_rd", {16'b0, dout_a[0]}, 32'h0000);
    check_eq("t1_rv", {31'b0, rv_a[0]}, 32'h1);

    wr(11'h000, 16'h78A1, 2'b11);
    rd(11'h000, 1);
    check_eq("t2_rd0", {16'b0, dout_a[0]}, 32'h78A1);
    check_eq("t2_rv0", {31'b0, rv_a[0]}, 32'h1);
    wr(11'h001, 16'h9066, 2'b11);
    rd(11'h001, 1);
    check_eq("t2_b2b", {16'b0, dout_a[0]}, 32'h9066);

    wr(11'h001, 16'hFFFF, 2'b01);
    rd(11'h001, 1);
    check_eq("t3_be01", {16'b0, dout_a[0]}, 32'h90FF);
    wr(11'h001, 16'hAAAA, 2'b00);
    rd(11'h001, 1);
    check_eq("t3_be00", {16'b0, dout_a[0]}, 32'h90FF);

    wr(11'h001, 16'h1234, 2'b11);
    check_eq("t4_wm0_dout", {16'b0, dout_a[0]}, 32'h90FF);
    check_eq("t4_wm0_rv", {31'b0, rv_a[0]}, 32'h0);
    check_eq("t4_wm1_dout", {16'b0, dout_a[1]}, 32'h1234);
    check_eq("t4_wm1_rv", {31'b0, rv_a[1]}, 32'h1);
    check_eq("t4_wm2_dout", {16'b0, dout_a[2]}, 32'h90FF);
    check_eq("t4_wm2_rv", {31'b0, rv_a[2]}, 32'h1);
    rd(11'h001, 1);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("t4_rd_%0d", k), {16'b0, dout_a[k]}, 32'h1234);

    rd(11'h000, 1);
    idle(1);
    check_eq("t5_lat2", {16'b0, dout_a[3]}, 32'h78A1);
    check_eq("t5_lat2_rv", {31'b0, rv_a[3]}, 32'h1);
    rd(11'h001, 1);
    rd(11'h000, 1);
    check_eq("t5_prev", {16'b0, dout_a[3]}, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      rd(11'h000, 0);
      check_eq("t5_hold", {16'b0, dout_a[3]}, 32'h1234);
      check_eq("t5_hold_rv", {31'b0, rv_a[3]}, 32'h0);
    end
    idle(1);
    check_eq("t5_oce", {16'b0, dout_a[3]}, 32'h78A1);
    check_eq("t5_oce_rv", {31'b0, rv_a[3]}, 32'h1);

    cycle(0, 0, 2'b00, 11'h0, 16'h0, 1, 0);
    check_eq("t6_rst_dout", {16'b0, dout_a[3]}, 32'h0);
    for (int i = 0; i < 100; i++) cycle(1, 1, 2'b11, 11'h005, 16'hBEEF, 1, 1);
    cycle(1, 1, 2'b11, 11'h005, 16'hBEEF, 1, 0);
    check_eq("t6_mid_busy", {31'b0, busy_a[0]}, 32'h1);
    sweep_len(1, n);
    check_eq("t6_busy_len", n, 2048);
    rd(11'h005, 1);
    check_eq("t6_dropped", {16'b0, dout_a[0]}, 32'h0000);

    for (int i = 0; i < 8; i++) wr(11'(i), 16'($urandom), 2'b11);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom),
            11'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3) != 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
